vid_timing_gen: RTL

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

---
 rtl/vid_timing_pkg.sv | 14 +
 rtl/vid_win_cmp.sv | 37 +++
 rtl/vid_timing_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// Shared defaults for the video timing generator and the helper that locates
// one window's field inside the packed NWIN*CW window buses.
package vid_timing_pkg;

  localparam int CW_DEF   = 12;
  localparam int NWIN_DEF = 2;
  localparam int DLY_DEF  = 2;

  // Window k of a packed NWIN*CW bus occupies [win_lsb(k, cw) +: cw].
  function automatic int win_lsb(input int k, input int cw);
    return k * cw;
  endfunction

endpackage

// File: rtl/vid_win_cmp.sv
// Single rectangular read-enable window test against active-area coordinates,
// registered so it lines up with the first decode stage of the top.
module vid_win_cmp
  import vid_timing_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst_n,
  input  logic          de,
  input  logic [CW-1:0] x_rel,
  input  logic [CW-1:0] y_rel,
  input  logic [CW-1:0] win_x,
  input  logic [CW-1:0] win_y,
  input  logic [CW-1:0] win_w,
  input  logic [CW-1:0] win_h,
  output logic          rden
);

  logic [CW:0] x_end;
  logic [CW:0] y_end;
  logic        hit;

  always_comb begin
    x_end = {1'b0, win_x} + {1'b0, win_w};
    y_end = {1'b0, win_y} + {1'b0, win_h};
    // Zero width or height yields an empty range, which disables the window.
    hit = de && (x_rel >= win_x) && ({1'b0, x_rel} < x_end)
             && (y_rel >= win_y) && ({1'b0, y_rel} < y_end);
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) rden <= 1'b0;
    else          rden <= hit;
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator: shadowed timing/window registers, H/V counters and
// a DLY-deep output pipeline with NWIN rectangular read-enable windows.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int NWIN = NWIN_DEF,
  parameter int DLY  = DLY_DEF
) (
  input  logic                 I_pxl_clk,
  input  logic                 I_rst_n,
  input  logic                 I_en,
  input  logic [CW-1:0]        I_h_total,
  input  logic [CW-1:0]        I_h_sync,
  input  logic [CW-1:0]        I_h_bporch,
  input  logic [CW-1:0]        I_h_res,
  input  logic [CW-1:0]        I_v_total,
  input  logic [CW-1:0]        I_v_sync,
  input  logic [CW-1:0]        I_v_bporch,
  input  logic [CW-1:0]        I_v_res,
  input  logic                 I_hs_pol,
  input  logic                 I_vs_pol,
  input  logic                 I_cfg_upd,
  input  logic [NWIN*CW-1:0]   I_win_x,
  input  logic [NWIN*CW-1:0]   I_win_y,
  input  logic [NWIN*CW-1:0]   I_win_w,
  input  logic [NWIN*CW-1:0]   I_win_h,
  output logic                 O_cfg_ack,
  output logic                 O_de,
  output logic                 O_hs,
  output logic                 O_vs,
  output logic [NWIN-1:0]      O_rden,
  output logic                 O_sof,
  output logic                 O_eol,
  output logic [CW-1:0]        O_x,
  output logic [CW-1:0]        O_y
);

  logic [CW-1:0]      h_total, h_sync, h_bporch, h_res;
  logic [CW-1:0]      v_total, v_sync, v_bporch, v_res;
  logic               hs_pol, vs_pol;
  logic [NWIN*CW-1:0] win_x, win_y, win_w, win_h;

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW:0]   h_nxt, v_nxt;
  logic          run, frame_end, load, cfg_ack;

  assign h_nxt = {1'b0, h_cnt} + (CW+1)'(1);
  assign v_nxt = {1'b0, v_cnt} + (CW+1)'(1);

  // A zero total means there is no raster to scan, so it behaves as disabled.
  assign run       = I_en && (h_total != '0) && (v_total != '0);
  assign frame_end = (h_nxt == {1'b0, h_total}) && (v_nxt == {1'b0, v_total});
  assign load      = I_cfg_upd && (!run || frame_end);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_total  <= '0; h_sync   <= '0; h_bporch <= '0; h_res <= '0;
      v_total  <= '0; v_sync   <= '0; v_bporch <= '0; v_res <= '0;
      hs_pol   <= 1'b0; vs_pol <= 1'b0;
      win_x    <= '0; win_y <= '0; win_w <= '0; win_h <= '0;
      cfg_ack  <= 1'b0;
    end else begin
      cfg_ack <= load;
      if (load) begin
        h_total  <= I_h_total;  h_sync   <= I_h_sync;
        h_bporch <= I_h_bporch; h_res    <= I_h_res;
        v_total  <= I_v_total;  v_sync   <= I_v_sync;
        v_bporch <= I_v_bporch; v_res    <= I_v_res;
        hs_pol   <= I_hs_pol;   vs_pol   <= I_vs_pol;
        win_x    <= I_win_x;    win_y    <= I_win_y;
        win_w    <= I_win_w;    win_h    <= I_win_h;
      end
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_nxt >= {1'b0, h_total}) begin
      h_cnt <= '0;
      v_cnt <= (v_nxt >= {1'b0, v_total}) ? '0 : v_nxt[CW-1:0];
    end else begin
      h_cnt <= h_nxt[CW-1:0];
    end
  end

  logic [CW:0]   h_act, h_end, h_lim, v_act, v_end, v_lim;
  logic          de0, hs0, vs0, sof0, eol0;
  logic [CW-1:0] x0, y0;

  always_comb begin
    h_act = {1'b0, h_sync} + {1'b0, h_bporch};
    h_end = h_act + {1'b0, h_res};
    h_lim = (h_end > {1'b0, h_total}) ? {1'b0, h_total} : h_end;
    v_act = {1'b0, v_sync} + {1'b0, v_bporch};
    v_end = v_act + {1'b0, v_res};
    v_lim = (v_end > {1'b0, v_total}) ? {1'b0, v_total} : v_end;

    de0  = run && ({1'b0, h_cnt} >= h_act) && ({1'b0, h_cnt} < h_lim)
               && ({1'b0, v_cnt} >= v_act) && ({1'b0, v_cnt} < v_lim);
    hs0  = (run && (h_cnt < h_sync)) ^ ~hs_pol;
    vs0  = (run && (v_cnt < v_sync)) ^ ~vs_pol;
    sof0 = de0 && ({1'b0, h_cnt} == h_act) && ({1'b0, v_cnt} == v_act);
    eol0 = de0 && (h_nxt == h_end);

    x0 = '0;
    y0 = '0;
    if (de0) begin
      x0 = h_cnt - h_act[CW-1:0];
      y0 = v_cnt - v_act[CW-1:0];
    end
  end

  // Window compares register internally, forming pipeline stage one for rden.
  logic [NWIN-1:0] rden_s1;

  for (genvar k = 0; k < NWIN; k++) begin : g_win
    vid_win_cmp #(.CW(CW)) u_win_cmp (
      .I_pxl_clk (I_pxl_clk),
      .I_rst_n   (I_rst_n),
      .de        (de0),
      .x_rel     (x0),
      .y_rel     (y0),
      .win_x     (win_x[win_lsb(k, CW) +: CW]),
      .win_y     (win_y[win_lsb(k, CW) +: CW]),
      .win_w     (win_w[win_lsb(k, CW) +: CW]),
      .win_h     (win_h[win_lsb(k, CW) +: CW]),
      .rden      (rden_s1[k])
    );
  end

  logic [DLY-1:0] de_q, hs_q, vs_q, sof_q, eol_q;
  logic [CW-1:0]  x_q [DLY];
  logic [CW-1:0]  y_q [DLY];

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q  <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
      sof_q <= '0;
      eol_q <= '0;
      for (int i = 0; i < DLY; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      de_q[0]  <= de0;
      hs_q[0]  <= hs0;
      vs_q[0]  <= vs0;
      sof_q[0] <= sof0;
      eol_q[0] <= eol0;
      x_q[0]   <= x0;
      y_q[0]   <= y0;
      for (int i = 1; i < DLY; i++) begin
        de_q[i]  <= de_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        sof_q[i] <= sof_q[i-1];
        eol_q[i] <= eol_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
    end
  end

  if (DLY == 1) begin : g_rden_d1
    assign O_rden = rden_s1;
  end else begin : g_rden_dn
    logic [NWIN-1:0] rden_q [DLY-1];

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        for (int i = 0; i < DLY-1; i++) rden_q[i] <= '0;
      end else begin
        rden_q[0] <= rden_s1;
        for (int i = 1; i < DLY-1; i++) rden_q[i] <= rden_q[i-1];
      end
    end

    assign O_rden = rden_q[DLY-2];
  end

  assign O_cfg_ack = cfg_ack;
  assign O_de      = de_q[DLY-1];
  assign O_hs      = hs_q[DLY-1];
  assign O_vs      = vs_q[DLY-1];
  assign O_sof     = sof_q[DLY-1];
  assign O_eol     = eol_q[DLY-1];
  assign O_x       = x_q[DLY-1];
  assign O_y       = y_q[DLY-1];

endmodule
